// File: rtl/sd_cmd_master_retry_if.sv
// Signal bundle between the SD command-path master and its host/bench side.
// The master modport is the controller's view; slave is the view of whatever drives it.
interface sd_cmd_master_retry_if #(
   parameter int TIMEOUT_W = 24,
   parameter int RETRY_W   = 2
);
   logic                 start_i;
   logic                 int_status_rst_i;
   logic [31:0]          argument_i;
   logic [13:0]          command_i;
   logic [TIMEOUT_W-1:0] timeout_i;
   logic [RETRY_W-1:0]   retry_max_i;
   logic [119:0]         response_i;
   logic                 crc_ok_i;
   logic                 index_ok_i;
   logic                 finish_i;
   logic                 busy_i;
   logic [1:0]           setting_o;
   logic                 start_xfr_o;
   logic                 go_idle_o;
   logic [39:0]          cmd_o;
   logic [4:0]           int_status_o;
   logic [31:0]          response_0_o;
   logic [31:0]          response_1_o;
   logic [31:0]          response_2_o;
   logic [31:0]          response_3_o;
   logic [RETRY_W-1:0]   retry_cnt_o;
   logic                 busy_o;

   modport master (
      input  start_i, int_status_rst_i, argument_i, command_i, timeout_i, retry_max_i,
             response_i, crc_ok_i, index_ok_i, finish_i, busy_i,
      output setting_o, start_xfr_o, go_idle_o, cmd_o, int_status_o,
             response_0_o, response_1_o, response_2_o, response_3_o, retry_cnt_o, busy_o
   );

   modport slave (
      output start_i, int_status_rst_i, argument_i, command_i, timeout_i, retry_max_i,
             response_i, crc_ok_i, index_ok_i, finish_i, busy_i,
      input  setting_o, start_xfr_o, go_idle_o, cmd_o, int_status_o,
             response_0_o, response_1_o, response_2_o, response_3_o, retry_cnt_o, busy_o
   );
endinterface

// File: rtl/sd_cmd_master_retry.sv
// SD command-path master: issues a command, checks the response and automatically
// re-issues it on CRC/index errors up to a latched retry budget.
module sd_cmd_master_retry #(
   parameter int TIMEOUT_W      = 24,
   parameter int RETRY_W        = 2,
   parameter int RETRY_GAP      = 8,
   parameter int GO_IDLE_CYCLES = 2
) (
   input logic                   sd_clk,
   input logic                   rst,
   sd_cmd_master_retry_if.master bus
);
   localparam int GAP_W  = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
   localparam int IDLE_W = (GO_IDLE_CYCLES > 1) ? $clog2(GO_IDLE_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_EXECUTE, S_BUSY_WAIT, S_GAP, S_ABORT} state_t;

   state_t               r_state, w_state_nxt;
   logic [39:0]          r_cmd_out;
   logic [1:0]           r_setting;
   logic                 r_idx_chk, r_crc_chk, r_busy_chk;
   logic [TIMEOUT_W-1:0] r_timeout, r_tcnt;
   logic [RETRY_W-1:0]   r_retry_max, r_retry_cnt;
   logic [GAP_W-1:0]     r_gap_cnt;
   logic [IDLE_W-1:0]    r_idle_cnt;
   logic                 r_start_xfr, r_go_idle;
   logic [4:0]           r_int_status;
   logic [31:0]          r_resp0, r_resp1, r_resp2, r_resp3;

   logic       w_accept, w_attempt, w_xfr_stop, w_retry, w_abort, w_status_we;
   logic [4:0] w_status_val;
   logic       w_crc_err, w_idx_err, w_expire, w_gap_done, w_abort_done;

   assign w_crc_err    = r_crc_chk & ~bus.crc_ok_i;
   assign w_idx_err    = r_idx_chk & ~bus.index_ok_i;
   // An attempt keeps start_xfr_o high for exactly timeout_i cycles before expiring.
   assign w_expire     = (r_timeout != '0) && ((r_tcnt + 1'b1) == r_timeout);
   assign w_gap_done   = (r_gap_cnt == GAP_W'(RETRY_GAP - 1));
   assign w_abort_done = (r_idle_cnt == IDLE_W'(GO_IDLE_CYCLES - 1));

   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_attempt    = 1'b0;
      w_xfr_stop   = 1'b0;
      w_retry      = 1'b0;
      w_abort      = 1'b0;
      w_status_we  = 1'b0;
      w_status_val = 5'b00000;
      unique case (r_state)
         S_IDLE: if (bus.start_i) begin
            w_accept    = 1'b1;
            w_attempt   = 1'b1;
            w_state_nxt = S_EXECUTE;
         end
         S_EXECUTE: if (bus.finish_i) begin
            w_xfr_stop = 1'b1;
            if (w_crc_err || w_idx_err) begin
               if (r_retry_cnt < r_retry_max) begin
                  w_retry     = 1'b1;
                  w_state_nxt = S_GAP;
               end else begin
                  w_status_we  = 1'b1;
                  w_status_val = {w_idx_err, w_crc_err, 3'b011};
                  w_state_nxt  = S_IDLE;
               end
            end else if (r_busy_chk && bus.busy_i) begin
               w_state_nxt = S_BUSY_WAIT;
            end else begin
               w_status_we  = 1'b1;
               w_status_val = 5'b00001;
               w_state_nxt  = S_IDLE;
            end
         end else if (w_expire) begin
            w_xfr_stop   = 1'b1;
            w_abort      = 1'b1;
            w_status_we  = 1'b1;
            w_status_val = 5'b00110;
            w_state_nxt  = S_ABORT;
         end
         S_BUSY_WAIT: if (!bus.busy_i) begin
            w_status_we  = 1'b1;
            w_status_val = 5'b00001;
            w_state_nxt  = S_IDLE;
         end else if (w_expire) begin
            w_abort      = 1'b1;
            w_status_we  = 1'b1;
            w_status_val = 5'b00110;
            w_state_nxt  = S_ABORT;
         end
         S_GAP: if (w_gap_done) begin
            w_attempt   = 1'b1;
            w_state_nxt = S_EXECUTE;
         end
         S_ABORT: if (w_abort_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
         r_cmd_out    <= '0;
         r_setting    <= '0;
         r_idx_chk    <= 1'b0;
         r_crc_chk    <= 1'b0;
         r_busy_chk   <= 1'b0;
         r_timeout    <= '0;
         r_tcnt       <= '0;
         r_retry_max  <= '0;
         r_retry_cnt  <= '0;
         r_gap_cnt    <= '0;
         r_idle_cnt   <= '0;
         r_start_xfr  <= 1'b0;
         r_go_idle    <= 1'b0;
         r_int_status <= '0;
         r_resp0      <= '0;
         r_resp1      <= '0;
         r_resp2      <= '0;
         r_resp3      <= '0;
      end else begin
         if (w_accept) begin
            r_cmd_out   <= {2'b01, bus.command_i[13:8], bus.argument_i};
            r_setting   <= bus.command_i[1:0];
            r_idx_chk   <= bus.command_i[4];
            r_crc_chk   <= bus.command_i[3];
            r_busy_chk  <= bus.command_i[2];
            r_timeout   <= bus.timeout_i;
            r_retry_max <= bus.retry_max_i;
            r_retry_cnt <= '0;
         end
         if (w_retry) r_retry_cnt <= r_retry_cnt + 1'b1;

         if (w_attempt) begin
            r_start_xfr <= 1'b1;
            r_tcnt      <= '0;
         end else if (r_state == S_EXECUTE || r_state == S_BUSY_WAIT) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
         if (w_xfr_stop) r_start_xfr <= 1'b0;

         if (r_state == S_EXECUTE && bus.finish_i) begin
            r_resp0 <= bus.response_i[119:88];
            r_resp1 <= bus.response_i[87:56];
            r_resp2 <= bus.response_i[55:24];
            r_resp3 <= {bus.response_i[23:0], 8'h00};
         end

         r_gap_cnt  <= (r_state == S_GAP)   ? r_gap_cnt + 1'b1  : '0;
         r_idle_cnt <= (r_state == S_ABORT) ? r_idle_cnt + 1'b1 : '0;
         if (w_abort)                               r_go_idle <= 1'b1;
         else if (r_state == S_ABORT && w_abort_done) r_go_idle <= 1'b0;

         // A status write takes priority over a coincident clear request.
         if (w_status_we)                          r_int_status <= w_status_val;
         else if (w_accept || bus.int_status_rst_i) r_int_status <= '0;
      end
   end

   assign bus.cmd_o        = r_cmd_out;
   assign bus.setting_o    = r_setting;
   assign bus.start_xfr_o  = r_start_xfr;
   assign bus.go_idle_o    = r_go_idle;
   assign bus.int_status_o = r_int_status;
   assign bus.response_0_o = r_resp0;
   assign bus.response_1_o = r_resp1;
   assign bus.response_2_o = r_resp2;
   assign bus.response_3_o = r_resp3;
   assign bus.retry_cnt_o  = r_retry_cnt;
   assign bus.busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_sd_cmd_master_retry.sv
// Directed bench for sd_cmd_master_retry: per-command results go through a scoreboard,
// cycle-level behaviour is checked inline with immediate assertions.
module tb_sd_cmd_master_retry;
   logic sd_clk = 1'b0;
   logic rst    = 1'b1;

   sd_cmd_master_retry_if #(.TIMEOUT_W(24), .RETRY_W(2)) bus ();

   sd_cmd_master_retry #(
      .TIMEOUT_W(24), .RETRY_W(2), .RETRY_GAP(8), .GO_IDLE_CYCLES(2)
   ) dut (
      .sd_clk (sd_clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 sd_clk = ~sd_clk;

   typedef struct {
      string       tag;
      logic [4:0]  st;
      logic [1:0]  rc;
      logic [31:0] r0, r1, r2, r3;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_xfr = 0;

   always @(posedge bus.start_xfr_o) n_xfr <= n_xfr + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sd_clk);
         #1;
      end
   endtask

   task automatic push(input string tag, input logic [4:0] st, input logic [1:0] rc,
                       input logic [31:0] r0, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] r3);
      exp_t e;
      e.tag = tag; e.st = st; e.rc = rc;
      e.r0 = r0; e.r1 = r1; e.r2 = r2; e.r3 = r3;
      sb.push_back(e);
   endtask

   // Wait (bounded) for the command to finish, then compare against the scoreboard head.
   task automatic wait_done();
      exp_t e;
      int   n = 0;
      while (bus.busy_o && n < 300) begin
         tick(1);
         n++;
      end
      check("done_wait", {63'd0, bus.busy_o}, 64'd0);
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
         e = sb.pop_front();
         check({e.tag, "_status"}, {59'd0, bus.int_status_o}, {59'd0, e.st});
         check({e.tag, "_retry"},  {62'd0, bus.retry_cnt_o},  {62'd0, e.rc});
         check({e.tag, "_resp0"},  {32'd0, bus.response_0_o}, {32'd0, e.r0});
         check({e.tag, "_resp1"},  {32'd0, bus.response_1_o}, {32'd0, e.r1});
         check({e.tag, "_resp2"},  {32'd0, bus.response_2_o}, {32'd0, e.r2});
         check({e.tag, "_resp3"},  {32'd0, bus.response_3_o}, {32'd0, e.r3});
      end
   endtask

   task automatic issue(input logic [31:0] arg, input logic [13:0] cmd,
                        input logic [23:0] tmo, input logic [1:0] rmax);
      bus.argument_i  = arg;
      bus.command_i   = cmd;
      bus.timeout_i   = tmo;
      bus.retry_max_i = rmax;
      bus.start_i     = 1'b1;
      tick(1);
      bus.start_i     = 1'b0;
   endtask

   task automatic finish(input logic [119:0] resp, input logic crc_ok, input logic idx_ok);
      bus.response_i = resp;
      bus.crc_ok_i   = crc_ok;
      bus.index_ok_i = idx_ok;
      bus.finish_i   = 1'b1;
      tick(1);
      bus.finish_i   = 1'b0;
   endtask

   initial begin
      int n;
      int x0;
      bus.start_i = 0; bus.int_status_rst_i = 0; bus.argument_i = 0; bus.command_i = 0;
      bus.timeout_i = 0; bus.retry_max_i = 0; bus.response_i = 0; bus.crc_ok_i = 0;
      bus.index_ok_i = 0; bus.finish_i = 0; bus.busy_i = 0;
      tick(2);
      check("rst_start_xfr", {63'd0, bus.start_xfr_o}, 64'd0);
      check("rst_cmd",       {24'd0, bus.cmd_o}, 64'd0);
      check("rst_status",    {59'd0, bus.int_status_o}, 64'd0);
      check("rst_busy",      {63'd0, bus.busy_o}, 64'd0);
      rst = 1'b0;
      tick(1);

      // Basic no-response command
      issue(32'h01234567, 14'h0100, 24'd100, 2'd0);
      check("t1_start_xfr", {63'd0, bus.start_xfr_o}, 64'd1);
      check("t1_setting",   {62'd0, bus.setting_o}, 64'd0);
      check("t1_cmd",       {24'd0, bus.cmd_o}, 64'h4101234567);
      push("t1", 5'b00001, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick(3);
      finish(120'h0, 1'b0, 1'b0);
      check("t1_xfr_low", {63'd0, bus.start_xfr_o}, 64'd0);
      wait_done();

      // Long response
      issue(32'hbad0dad0, 14'h1503, 24'd100, 2'd0);
      check("t2_status_clr", {59'd0, bus.int_status_o}, 64'd0);
      check("t2_setting",    {62'd0, bus.setting_o}, 64'd3);
      check("t2_cmd",        {24'd0, bus.cmd_o}, 64'h55bad0dad0);
      push("t2", 5'b00001, 2'd0, 32'h11121314, 32'h15161718, 32'h191a1b1c, 32'h1d1e1f00);
      tick(2);
      finish(120'h1112131415161718191a1b1c1d1e1f, 1'b1, 1'b1);
      wait_done();

      // Status clear request
      bus.int_status_rst_i = 1'b1;
      tick(1);
      bus.int_status_rst_i = 1'b0;
      check("stat_rst", {59'd0, bus.int_status_o}, 64'd0);

      // Retry recovery
      issue(32'hcafef00d, 14'h2519, 24'd100, 2'd2);
      push("t3", 5'b00001, 2'd1, 32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'hdddddd00);
      tick(2);
      finish(120'h0, 1'b0, 1'b1);
      check("t3_gap_status", {59'd0, bus.int_status_o}, 64'd0);
      check("t3_gap_retry",  {62'd0, bus.retry_cnt_o}, 64'd1);
      n = 0;
      while (!bus.start_xfr_o && n < 50) begin
         n++;
         tick(1);
      end
      check("t3_gap_len", 64'(n), 64'd8);
      check("t3_cmd_same", {24'd0, bus.cmd_o}, 64'h65cafef00d);
      tick(2);
      finish(120'haaaaaaaabbbbbbbbccccccccdddddd, 1'b1, 1'b1);
      wait_done();

      // Retry exhausted
      x0 = n_xfr;
      issue(32'h00000000, 14'h2519, 24'd100, 2'd1);
      push("t4", 5'b11011, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
      tick(2);
      finish(120'h0, 1'b0, 1'b0);
      n = 0;
      while (!bus.start_xfr_o && n < 50) begin
         n++;
         tick(1);
      end
      tick(2);
      finish(120'h0, 1'b0, 1'b0);
      wait_done();
      check("t4_xfr_count", 64'(n_xfr - x0), 64'd2);

      // Timeout then abort
      issue(32'h0, 14'h0100, 24'd10, 2'd3);
      push("t5", 5'b00110, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      n = 0;
      while (bus.start_xfr_o && n < 200) begin
         n++;
         tick(1);
      end
      check("t5_xfr_len", 64'(n), 64'd10);
      check("t5_status",  {59'd0, bus.int_status_o}, 64'd6);
      n = 0;
      while (bus.go_idle_o && n < 50) begin
         n++;
         tick(1);
      end
      check("t5_go_idle_len", 64'(n), 64'd2);
      wait_done();

      // Follow-up CMD5 after abort
      issue(32'h0, 14'h0501, 24'd100, 2'd0);
      check("t5b_cmd",     {24'd0, bus.cmd_o}, 64'h4500000000);
      check("t5b_setting", {62'd0, bus.setting_o}, 64'd1);
      push("t5b", 5'b00001, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick(1);
      finish(120'h0, 1'b1, 1'b1);
      wait_done();

      // finish_i in the same cycle the timeout would expire: finish wins
      issue(32'h0, 14'h0100, 24'd4, 2'd0);
      push("t5c", 5'b00001, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick(3);
      finish(120'h0, 1'b1, 1'b1);
      check("t5c_go_idle", {63'd0, bus.go_idle_o}, 64'd0);
      wait_done();

      // Busy wait, with an ignored start request while busy
      issue(32'h00000042, 14'h7505, 24'd0, 2'd0);
      push("t6", 5'b00001, 2'd0, 32'h80000000, 32'h0, 32'h0, 32'h0);
      tick(2);
      bus.busy_i = 1'b1;
      finish(120'h800000000000000000000000000000, 1'b1, 1'b1);
      issue(32'hffffffff, 14'h3f00, 24'd5, 2'd0);
      tick(3);
      check("t6_cmd_kept",   {24'd0, bus.cmd_o}, 64'h7500000042);
      check("t6_busy_stat",  {59'd0, bus.int_status_o}, 64'd0);
      check("t6_busy_o",     {63'd0, bus.busy_o}, 64'd1);
      bus.busy_i = 1'b0;
      tick(1);
      check("t6_done_stat",  {59'd0, bus.int_status_o}, 64'd1);
      wait_done();

      // Asynchronous reset mid-EXECUTE
      issue(32'h01234567, 14'h0100, 24'd100, 2'd0);
      tick(2);
      check("t7_pre_xfr", {63'd0, bus.start_xfr_o}, 64'd1);
      rst = 1'b1;
      #1;
      check("t7_xfr",     {63'd0, bus.start_xfr_o}, 64'd0);
      check("t7_cmd",     {24'd0, bus.cmd_o}, 64'd0);
      check("t7_busy",    {63'd0, bus.busy_o}, 64'd0);
      check("t7_resp0",   {32'd0, bus.response_0_o}, 64'd0);
      check("t7_setting", {62'd0, bus.setting_o}, 64'd0);
      check("t7_status",  {59'd0, bus.int_status_o}, 64'd0);
      check("t7_sb_left", 64'(sb.size()), 64'd0);
      tick(2);
      rst = 1'b0;
      tick(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sd_cmd_master_retry.md
Name: sd_cmd_master_retry

Overview:
- Command-path master for the SD controller, successor to the single-shot command master.
- Latches a command/argument, drives the serial command host (start_xfr_o, cmd_o, setting_o) and captures the response.
- Checks CRC, index and busy, with per-command timeout; on a CRC or index error it automatically re-issues the command up to a programmable retry count.
- Reports a single final interrupt status per command.

Parameters:
TIMEOUT_W, 24, width of timeout_i and internal timeout counter
RETRY_W, 2, width of retry_max_i and retry_cnt_o
RETRY_GAP, 8, sd_clk cycles start_xfr_o held low between attempts (>=1)
GO_IDLE_CYCLES, 2, cycles go_idle_o is held high after a timeout (>=1)

Ports:
sd_clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
start_i  in  1  start pulse; sampled only in IDLE
int_status_rst_i  in  1  clears int_status_o
argument_i  in  32  command argument, latched on accepted start
command_i  in  14  [13:8] index, [4] index check, [3] CRC check, [2] busy check, [1:0] response type; latched on accepted start
timeout_i  in  TIMEOUT_W  per-attempt timeout in sd_clk cycles; 0 disables
retry_max_i  in  RETRY_W  extra attempts allowed; latched on accepted start
response_i  in  120  response bits from command host
crc_ok_i  in  1  response CRC valid, qualified by finish_i
index_ok_i  in  1  response index valid, qualified by finish_i
finish_i  in  1  command host done (1-cycle pulse)
busy_i  in  1  DAT0 busy from card
setting_o  out  2  response type for host
start_xfr_o  out  1  level: attempt in progress
go_idle_o  out  1  abort request to host
cmd_o  out  40  {2'b01, index[5:0], argument[31:0]}
int_status_o  out  5  [0] CC, [1] EI, [2] CTE, [3] CCRCE, [4] CIE
response_0_o..response_3_o  out  32 each  response words
retry_cnt_o  out  RETRY_W  retries consumed by current/last command
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; counters and latched fields cleared.
- States: IDLE, EXECUTE, BUSY_WAIT, GAP, ABORT.
- IDLE + start_i:
  - latch argument_i, command_i, timeout_i, retry_max_i; clear int_status_o and retry_cnt_o;
  - next cycle: EXECUTE, start_xfr_o=1, cmd_o and setting_o valid (1-cycle latency).
- start_i outside IDLE is ignored.
- EXECUTE:
  - timeout counter increments each cycle from 0, reset at each attempt start;
  - when timeout_i!=0 and count reaches timeout_i before finish_i: start_xfr_o=0, int_status_o=5'b00110, enter ABORT.
  - Timeouts are never retried.
- finish_i in EXECUTE:
  - capture response_0_o=response_i[119:88], _1=[87:56], _2=[55:24], _3={response_i[23:0],8'h00};
  - crc_err = cmd[3] & ~crc_ok_i; idx_err = cmd[4] & ~index_ok_i;
  - start_xfr_o=0 next cycle.
- Error with retry_cnt_o < latched retry_max: increment retry_cnt_o, enter GAP; no status written.
- Error with no retries left: int_status_o = {idx_err, crc_err, 0, 1, 1}; go IDLE.
- No error:
  - cmd[2] & busy_i at finish: go BUSY_WAIT;
  - otherwise int_status_o=5'b00001, go IDLE.
- BUSY_WAIT:
  - timeout counter keeps running;
  - first cycle busy_i sampled low: int_status_o=5'b00001 on the following edge, go IDLE;
  - timeout expiry: same handling as EXECUTE timeout.
- GAP: start_xfr_o=0 for exactly RETRY_GAP cycles, then EXECUTE with the same cmd_o/setting_o and the timeout counter cleared.
- ABORT: go_idle_o=1 for exactly GO_IDLE_CYCLES cycles, then go_idle_o=0 and IDLE.
- int_status_rst_i clears int_status_o in any state. If it coincides with a status write, the write wins.
- retry_cnt_o saturates at the latched retry_max; no wrap-around.
- finish_i and timeout expiry in the same cycle: finish_i wins.
- finish_i outside EXECUTE is ignored.

Test Plan:
- Basic no-response: arg 32'h01234567, cmd 14'h0100, timeout 100 -> next cycle start_xfr_o=1, setting_o=00, cmd_o=40'h4101234567; finish -> int_status_o=1, start_xfr_o=0.
- Long response: cmd 14'h1503, finish with response 120'h1112…1f -> response_0..3 = 11121314/15161718/191a1b1c/1d1e1f00, setting_o=11, cmd_o=40'h55bad0dad0.
- Retry recovery: cmd 14'h2519, retry_max 2, first finish crc_ok=0 -> no status, start_xfr_o low 8 cycles, then re-asserted; second finish crc_ok=index_ok=1 -> status 1, retry_cnt_o=1.
- Retry exhausted: retry_max 1, both finishes with crc_ok=index_ok=0 -> status 5'b11011, retry_cnt_o=1, two start_xfr_o assertions total.
- Timeout: timeout 10, no finish -> status 5'b00110, go_idle_o high 2 cycles; follow-up normal CMD5 (cmd 14'h0501) completes with status 1.
- Busy and reset: cmd 14'h7505 with busy_i=1 at finish -> status 0 until 1 cycle after busy_i drops, then 1; separately, assert rst mid-EXECUTE -> all outputs 0 immediately.
